// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache store.
// Imported by the top level; the LRU tracker needs only its own widths.
package cache_pkg;

    // Metadata tag field is sized for the widest supported address; each
    // instance uses only its low TAG_BITS.
    localparam int MAX_TAG_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [MAX_TAG_BITS-1:0] tag;
    } line_meta_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_bits(input int addr_size, input int num_sets,
                                    input int words_per_block, input int data_width);
        return addr_size - $clog2(num_sets) - $clog2(words_per_block)
               - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age vectors, one per set: age 0 is most recent, NUM_WAYS-1 is the
// replacement candidate. Ages always form a permutation of 0..NUM_WAYS-1.
module lru_tracker #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    parameter int SET_BITS = 2,
    parameter int WAY_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_touch_valid,
    input  logic [SET_BITS-1:0] i_touch_set,
    input  logic [WAY_BITS-1:0] i_touch_way,
    input  logic                i_init_valid,
    input  logic [SET_BITS-1:0] i_init_set,
    input  logic [SET_BITS-1:0] i_query_set,
    output logic [WAY_BITS-1:0] o_oldest_way
);

    logic [WAY_BITS-1:0] r_age [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0] w_touch_age;

    assign w_touch_age = r_age[i_touch_set][i_touch_way];

    // NOTE: sequential state uses non-blocking assignments so every loop
    // iteration compares against the pre-edge ages, not partially updated ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_age[s][w] <= WAY_BITS'(w);
                end
            end
        end else if (i_init_valid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_age[i_init_set][w] <= WAY_BITS'(w);
            end
        end else if (i_touch_valid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) == i_touch_way) begin
                    r_age[i_touch_set][w] <= '0;
                end else if (r_age[i_touch_set][w] < w_touch_age) begin
                    r_age[i_touch_set][w] <= r_age[i_touch_set][w] + 1'b1;
                end
            end
        end
    end

    // NOTE: the output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_oldest_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[i_query_set][w] == WAY_BITS'(NUM_WAYS - 1)) begin
                o_oldest_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/cache_memory_lru.sv
// Set-associative tag/data store with dirty tracking, true-LRU victim
// reporting, sequenced line fill and a set-walking flush.
module cache_memory_lru
    import cache_pkg::*;
#(
    parameter  int ADDR_SIZE       = 32,
    parameter  int NUM_SETS        = 4,
    parameter  int NUM_WAYS        = 2,
    parameter  int WORDS_PER_BLOCK = 4,
    parameter  int DATA_WIDTH      = 32,
    localparam int SET_BITS        = idx_bits(NUM_SETS),
    localparam int WAY_BITS        = idx_bits(NUM_WAYS),
    localparam int WORD_BITS       = idx_bits(WORDS_PER_BLOCK),
    localparam int BE_BITS         = DATA_WIDTH / 8,
    localparam int TAG_BITS        = tag_bits(ADDR_SIZE, NUM_SETS, WORDS_PER_BLOCK, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [SET_BITS-1:0]   set,
    input  logic [TAG_BITS-1:0]   tag,
    input  logic [WORD_BITS-1:0]  word,
    input  logic [BE_BITS-1:0]    byte_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  hit,
    output logic [WAY_BITS-1:0]   hit_way,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [WAY_BITS-1:0]   victim_way,
    output logic                  victim_valid,
    output logic                  victim_dirty,
    output logic [TAG_BITS-1:0]   victim_tag,
    input  logic                  fill_start,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_done,
    input  logic                  flush_start,
    output logic                  busy
);

    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_BLOCK - 1);
    localparam logic [SET_BITS-1:0]  LAST_SET  = SET_BITS'(NUM_SETS - 1);

    state_t                r_state;
    line_meta_t            r_meta [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] r_data [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];

    logic [SET_BITS-1:0]   r_fill_set;
    logic [TAG_BITS-1:0]   r_fill_tag;
    logic [WAY_BITS-1:0]   r_fill_way;
    logic [WORD_BITS-1:0]  r_fill_word;
    logic [SET_BITS-1:0]   r_flush_set;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_fill_done;

    logic                  w_hit;
    logic [WAY_BITS-1:0]   w_hit_way;
    logic [WAY_BITS-1:0]   w_oldest_way;
    logic [WAY_BITS-1:0]   w_victim_way;
    logic                  w_any_invalid;
    logic                  w_do_req;
    logic                  w_fill_beat;
    logic                  w_fill_last;
    logic                  w_touch_valid;
    logic [SET_BITS-1:0]   w_touch_set;
    logic [WAY_BITS-1:0]   w_touch_way;
    logic                  w_dwe;
    logic [SET_BITS-1:0]   w_dset;
    logic [WAY_BITS-1:0]   w_dway;
    logic [WORD_BITS-1:0]  w_dword;
    logic [BE_BITS-1:0]    w_dbe;
    logic [DATA_WIDTH-1:0] w_dwdata;

    // Lookup: lowest matching way wins; no hits are reported while busy.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_meta[set][w].valid && r_meta[set][w].tag[TAG_BITS-1:0] == tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
        end
        if (r_state != IDLE) begin
            w_hit     = 1'b0;
            w_hit_way = '0;
        end
    end

    // Replacement: an empty way is always preferred over evicting the oldest.
    always_comb begin
        w_any_invalid = 1'b0;
        w_victim_way  = w_oldest_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_meta[set][w].valid) begin
                w_any_invalid = 1'b1;
                w_victim_way  = WAY_BITS'(w);
            end
        end
    end

    assign w_do_req    = (r_state == IDLE) && !flush_start && !fill_start && req_valid && w_hit;
    assign w_fill_beat = (r_state == FILL) && fill_valid;
    assign w_fill_last = w_fill_beat && (r_fill_word == LAST_WORD);

    assign w_touch_valid = w_do_req || w_fill_last;
    assign w_touch_set   = w_fill_last ? r_fill_set : set;
    assign w_touch_way   = w_fill_last ? r_fill_way : w_hit_way;

    lru_tracker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .SET_BITS (SET_BITS),
        .WAY_BITS (WAY_BITS)
    ) u_lru (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_touch_valid (w_touch_valid),
        .i_touch_set   (w_touch_set),
        .i_touch_way   (w_touch_way),
        .i_init_valid  (r_state == FLUSH),
        .i_init_set    (r_flush_set),
        .i_query_set   (set),
        .o_oldest_way  (w_oldest_way)
    );

    // Single data write port shared by store hits (IDLE) and fill beats (FILL).
    assign w_dwe    = (w_do_req && req_write) || w_fill_beat;
    assign w_dset   = w_fill_beat ? r_fill_set  : set;
    assign w_dway   = w_fill_beat ? r_fill_way  : w_hit_way;
    assign w_dword  = w_fill_beat ? r_fill_word : word;
    assign w_dbe    = w_fill_beat ? {BE_BITS{1'b1}} : byte_en;
    assign w_dwdata = w_fill_beat ? fill_data   : write_data;

    // NOTE: the data array has no reset; validity lives in the metadata, and
    // leaving storage unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_dwe) begin
            for (int b = 0; b < BE_BITS; b++) begin
                if (w_dbe[b]) begin
                    r_data[w_dset][w_dway][w_dword][b*8 +: 8] <= w_dwdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_fill_set   <= '0;
            r_fill_tag   <= '0;
            r_fill_way   <= '0;
            r_fill_word  <= '0;
            r_flush_set  <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_fill_done  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_meta[s][w] <= '0;
                end
            end
        end else begin
            r_read_valid <= 1'b0;
            r_fill_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_start) begin
                        r_flush_set <= '0;
                        r_state     <= FLUSH;
                    end else if (fill_start) begin
                        r_fill_set  <= set;
                        r_fill_tag  <= tag;
                        r_fill_way  <= w_victim_way;
                        r_fill_word <= '0;
                        r_state     <= FILL;
                    end else if (w_do_req) begin
                        if (req_write) begin
                            r_meta[set][w_hit_way].dirty <= 1'b1;
                        end else begin
                            r_read_data  <= r_data[set][w_hit_way][word];
                            r_read_valid <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        r_fill_word <= r_fill_word + 1'b1;
                        if (r_fill_word == LAST_WORD) begin
                            r_meta[r_fill_set][r_fill_way] <= '{valid: 1'b1, dirty: 1'b0,
                                                               tag: MAX_TAG_BITS'(r_fill_tag)};
                            r_fill_done <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        r_meta[r_flush_set][w] <= '0;
                    end
                    r_flush_set <= r_flush_set + 1'b1;
                    if (r_flush_set == LAST_SET) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hit          = w_hit;
    assign hit_way      = w_hit_way;
    assign read_data    = r_read_data;
    assign read_valid   = r_read_valid;
    assign victim_way   = w_victim_way;
    assign victim_valid = r_meta[set][w_victim_way].valid;
    assign victim_dirty = r_meta[set][w_victim_way].dirty;
    assign victim_tag   = r_meta[set][w_victim_way].tag[TAG_BITS-1:0];
    assign fill_done    = r_fill_done;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_cache_memory_lru.sv
// Directed bench for cache_memory_lru in its default configuration; read
// results are checked through a scoreboard queue filled as reads are issued.
module tb_cache_memory_lru;

    localparam int TAG_BITS = 26;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_write;
    logic [1:0]          set;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          word;
    logic [3:0]          byte_en;
    logic [31:0]         write_data;
    logic                hit;
    logic [0:0]          hit_way;
    logic [31:0]         read_data;
    logic                read_valid;
    logic [0:0]          victim_way;
    logic                victim_valid;
    logic                victim_dirty;
    logic [TAG_BITS-1:0] victim_tag;
    logic                fill_start;
    logic                fill_valid;
    logic [31:0]         fill_data;
    logic                fill_done;
    logic                flush_start;
    logic                busy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    cache_memory_lru dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .set          (set),
        .tag          (tag),
        .word         (word),
        .byte_en      (byte_en),
        .write_data   (write_data),
        .hit          (hit),
        .hit_way      (hit_way),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .fill_start   (fill_start),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .fill_done    (fill_done),
        .flush_start  (flush_start),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [1:0] s, input logic [TAG_BITS-1:0] t);
        set = s;
        tag = t;
        #1;
    endtask

    task automatic do_read(input logic [1:0] s, input logic [TAG_BITS-1:0] t,
                           input logic [1:0] w, input logic [0:0] exp_way,
                           input logic [31:0] exp_data);
        set = s; tag = t; word = w;
        req_write = 1'b0;
        req_valid = 1'b1;
        #1;
        check("rd_hit", hit, 1);
        check("rd_hit_way", hit_way, exp_way);
        exp_q.push_back(exp_data);
        tick();
        req_valid = 1'b0;
        check("rd_valid", read_valid, 1);
    endtask

    task automatic do_write(input logic [1:0] s, input logic [TAG_BITS-1:0] t,
                            input logic [1:0] w, input logic [3:0] be, input logic [31:0] d);
        set = s; tag = t; word = w; byte_en = be; write_data = d;
        req_write = 1'b1;
        req_valid = 1'b1;
        #1;
        check("wr_hit", hit, 1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Fill with an idle cycle before word gap_before; a read issued in that
    // gap must be ignored, and probe_tag must not hit while busy.
    task automatic fill_line(input logic [1:0] s, input logic [TAG_BITS-1:0] t,
                             input logic [31:0] base, input int gap_before,
                             input logic [TAG_BITS-1:0] probe_tag, input logic [0:0] exp_way);
        set = s; tag = t;
        fill_start = 1'b1;
        #1;
        check("fill_victim", victim_way, exp_way);
        tick();
        fill_start = 1'b0;
        check("fill_busy", busy, 1);
        tag = probe_tag;
        #1;
        check("busy_no_hit", hit, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_before) begin
                fill_valid = 1'b0;
                req_valid  = 1'b1;
                tick();
                req_valid  = 1'b0;
            end
            check("fill_done_early", fill_done, 0);
            fill_valid = 1'b1;
            fill_data  = base + 32'(i);
            tick();
        end
        fill_valid = 1'b0;
        check("fill_done", fill_done, 1);
        check("fill_idle", busy, 0);
        tick();
        check("fill_done_pulse", fill_done, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && read_valid) begin
            if (exp_q.size() == 0) check("unexpected_read_valid", read_valid, 0);
            else check("rd_data", read_data, exp_q.pop_front());
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; set = '0; tag = '0;
        word = '0; byte_en = '0; write_data = '0; fill_start = 1'b0;
        fill_valid = 1'b0; fill_data = '0; flush_start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("rst_busy", busy, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_read_data", read_data, 0);
        check("rst_fill_done", fill_done, 0);

        // Miss on empty cache: no hit, no read_valid.
        set = 2'd0; tag = 26'h1234; word = 2'd0; req_valid = 1'b1;
        #1;
        check("miss_hit", hit, 0);
        check("miss_victim_way", victim_way, 0);
        check("miss_victim_valid", victim_valid, 0);
        tick();
        req_valid = 1'b0;
        check("miss_read_valid", read_valid, 0);

        fill_line(2'd0, 26'h1234, 32'hA0, 2, 26'h1234, 1'b0);
        do_read(2'd0, 26'h1234, 2'd2, 1'b0, 32'h0000_00A2);
        probe(2'd0, 26'h1234);
        check("after_fill_victim", victim_way, 1);
        probe(2'd1, 26'h1234);
        check("other_set_miss", hit, 0);

        do_write(2'd0, 26'h1234, 2'd1, 4'b0011, 32'hFFFF_FFFF);
        do_read(2'd0, 26'h1234, 2'd1, 1'b0, 32'h0000_FFFF);
        probe(2'd0, 26'h1234);
        check("wr_victim_way", victim_way, 1);
        check("wr_victim_dirty", victim_dirty, 0);

        fill_line(2'd0, 26'h5678, 32'hB0, 1, 26'h1234, 1'b1);
        probe(2'd0, 26'h5678);
        check("lru_victim_way", victim_way, 0);
        check("lru_victim_valid", victim_valid, 1);
        check("lru_victim_dirty", victim_dirty, 1);
        check("lru_victim_tag", victim_tag, 26'h1234);
        do_read(2'd0, 26'h5678, 2'd3, 1'b1, 32'h0000_00B3);
        do_read(2'd0, 26'h1234, 2'd1, 1'b0, 32'h0000_FFFF);
        check("touch_victim_way", victim_way, 1);
        check("touch_victim_tag", victim_tag, 26'h5678);
        check("touch_victim_dirty", victim_dirty, 0);

        fill_line(2'd0, 26'h9ABC, 32'hC0, 3, 26'h1234, 1'b1);
        do_read(2'd0, 26'h1234, 2'd1, 1'b0, 32'h0000_FFFF);
        do_read(2'd0, 26'h9ABC, 2'd0, 1'b1, 32'h0000_00C0);
        probe(2'd0, 26'h5678);
        check("evicted_miss", hit, 0);
        do_write(2'd0, 26'h9ABC, 2'd3, 4'b1100, 32'h1234_5678);
        do_read(2'd0, 26'h9ABC, 2'd3, 1'b1, 32'h1234_00C3);

        // Flush beats a simultaneous fill_start.
        set = 2'd1; tag = 26'h0DEF;
        flush_start = 1'b1;
        fill_start  = 1'b1;
        tick();
        flush_start = 1'b0;
        fill_start  = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 10) begin
            cnt++;
            tick();
        end
        check("flush_len", cnt, 4);
        probe(2'd0, 26'h1234);
        check("flush_miss_a", hit, 0);
        check("flush_victim_way", victim_way, 0);
        check("flush_victim_valid", victim_valid, 0);
        probe(2'd0, 26'h9ABC);
        check("flush_miss_b", hit, 0);
        probe(2'd1, 26'h0DEF);
        check("flush_no_fill", hit, 0);

        // Reset in the middle of a fill aborts it.
        set = 2'd3; tag = 26'h0777;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fill_valid = 1'b1;
            fill_data  = 32'hD0 + 32'(i);
            tick();
        end
        fill_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_fill_done", fill_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        probe(2'd3, 26'h0777);
        check("abort_miss", hit, 0);
        check("abort_victim_valid", victim_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_memory_lru.md
# cache_memory_lru

Set-associative tag/data store for the data cache, parametrised in sets, ways, words per block and word width. It adds per-line dirty tracking, true-LRU replacement with victim reporting, a sequenced multi-word line fill and a set-walking flush. It sits between the core load/store path and the cache controller, which drives fills and write-backs from the victim outputs.

## Interface
- ADDR_SIZE, 32, byte address width
- NUM_SETS, 4, sets; power of 2, ≥2
- NUM_WAYS, 2, ways; power of 2, 2..8
- WORDS_PER_BLOCK, 4, words per line; power of 2, ≥2
- DATA_WIDTH, 32, word width; multiple of 8
- Derived widths: SetBits=$clog2(NUM_SETS), WayBits=$clog2(NUM_WAYS), WordBits=$clog2(WORDS_PER_BLOCK), ByteBits=$clog2(DATA_WIDTH/8), TagBits=ADDR_SIZE-SetBits-WordBits-ByteBits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request this cycle
- req_write  in  1  1 = write, 0 = read
- set  in  SetBits  set index (requests, fill start)
- tag  in  TagBits  tag (requests, fill start)
- word  in  WordBits  word offset within line
- byte_en  in  DATA_WIDTH/8  byte enables for writes
- write_data  in  DATA_WIDTH  write word
- hit  out  1  combinational; tag matches a valid way in `set` and block idle
- hit_way  out  WayBits  matching way; 0 when no hit
- read_data  out  DATA_WIDTH  registered read word
- read_valid  out  1  read_data valid, one cycle after a read hit
- victim_way  out  WayBits  combinational replacement way for `set`
- victim_valid / victim_dirty  out  1 each  state of that victim line
- victim_tag  out  TagBits  victim tag, for write-back address
- fill_start  in  1  begin fill of `set`/`tag` into victim_way
- fill_valid  in  1  fill word present
- fill_data  in  DATA_WIDTH  fill word, ascending word order
- fill_done  out  1  one-cycle pulse; line installed
- flush_start  in  1  invalidate the whole cache
- busy  out  1  high in FILL or FLUSH

## Operation
- FSM: IDLE, FILL, FLUSH.
- IDLE priority: flush_start > fill_start > req_valid. Lower-priority inputs in the same cycle are dropped, not queued.
- Read hit: read_data registered from hit_way/word. read_valid asserts next cycle. LRU updated.
- Write hit: bytes with byte_en set are written. Line dirty←1. LRU updated.
- Misses change no state. read_valid stays 0.
- Victim: lowest-index invalid way; otherwise the way with age NUM_WAYS-1.
- fill_start: latch set, tag and victim_way, clear word counter, go to FILL. The old line stays readable until installed; hit is forced 0 while busy.
- FILL: each fill_valid writes fill_data to word[counter], then counter++. On the last word: tag written, valid←1, dirty←0, LRU touch, fill_done pulse, return to IDLE. Gaps in fill_valid are allowed.
- FLUSH: walk sets 0..NUM_SETS-1, one per cycle, clearing valid and dirty and reinitialising ages. Return to IDLE after set NUM_SETS-1. Dirty data is discarded; write-back is the controller's duty beforehand.
- LRU touch of way w: every way with age < age[w] increments; age[w]←0. Ages stay a permutation of 0..NUM_WAYS-1.
- req_valid, fill_start and flush_start are ignored while busy.

## Timing
- Reset values: all valid/dirty 0, age[way]=way for every set, state IDLE, read_valid 0, read_data 0, fill_done 0, busy 0. Data array is not reset.
- Reset during FILL or FLUSH aborts immediately; any partial line is discarded.
- hit, hit_way and victim_* are combinational from set/tag and current state.
- Read latency: 1 cycle. Write, dirty and LRU updates are visible the cycle after the edge.
- Fill: busy rises the cycle after fill_start. fill_done coincides with the first cycle the line hits. Minimum duration WORDS_PER_BLOCK cycles.
- Flush: busy for exactly NUM_SETS cycles.

## Structure
- Package cache_pkg: width helper functions, state enum {IDLE, FILL, FLUSH}, line-metadata struct {valid, dirty, tag}.
- Sub-module lru_tracker: per-set age vectors. Provides touch(set, way), victim(set) and reset/flush init.

## Test plan
Configuration: defaults (4 sets, 2 ways, 4 words, 32-bit).
- Reset, then read set 0 tag 0x1234 → hit=0, victim_way=0, victim_valid=0.
- fill_start set 0 tag 0x1234, then 4 words 0xA0..0xA3 with one idle gap → fill_done after 4th word; read word 2 → read_data=0xA2 one cycle later; victim_way=1.
- Write word 1 byte_en=4'b0011 data 0xFFFFFFFF → read returns 0x0000FFFF (assuming fill word 0x000000A1 → 0x0000FFFF); victim_dirty=0 for way 1, dirty set for way 0.
- Fill tag 0x5678 into way 1, then read tag 0x1234 → victim_way=1. Fill tag 0x9ABC → replaces way 1; tag 0x1234 still hits.
- flush_start and fill_start together → flush wins; busy for 4 cycles; all lookups miss afterwards.
- rst_n low after 2 fill words → busy=0 immediately; target line invalid after release.
